// File: rtl/add_rs.sv
// add_rs: reservation station for the add/sub/logic functional unit.
// Holds up to ENTRIES instructions, snoops the CDB for pending operands and
// issues one READY entry per cycle when the ALU reports available.
// Optional macro RS_AGE_ORDER_EN: issue the oldest READY entry instead of the
// lowest-index one.

// One station slot: owns a fixed label and walks FREE -> WAIT/READY -> EXEC -> FREE.
module add_rs_entry #(
  parameter int          DW    = 32,
  parameter logic [3:0]  LABEL = 4'd1
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          wr,
  input  logic [1:0]    wr_op,
  input  logic [3:0]    wr_qj,
  input  logic [DW-1:0] wr_vj,
  input  logic [3:0]    wr_qk,
  input  logic [DW-1:0] wr_vk,
  input  logic          cdb_valid,
  input  logic [3:0]    cdb_label,
  input  logic [DW-1:0] cdb_data,
  input  logic          iss,
  output logic          is_free,
  output logic          is_ready,
  output logic [1:0]    op,
  output logic [DW-1:0] vj,
  output logic [DW-1:0] vk
);
  typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} state_t;

  state_t     state;
  logic [3:0] qj, qk;
  logic       hit_j, hit_k;

  // Label 0 means "no producer", so it never matches a broadcast.
  assign hit_j    = cdb_valid && (qj != 4'd0) && (qj == cdb_label);
  assign hit_k    = cdb_valid && (qk != 4'd0) && (qk == cdb_label);
  assign is_free  = (state == FREE);
  assign is_ready = (state == READY);

  // Slot state machine: dispatch write, operand capture, issue and release.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= FREE;
      op    <= '0;
      qj    <= '0;
      vj    <= '0;
      qk    <= '0;
      vk    <= '0;
    end else begin
      case (state)
        FREE: if (wr) begin
          op    <= wr_op;
          qj    <= wr_qj;
          vj    <= wr_vj;
          qk    <= wr_qk;
          vk    <= wr_vk;
          state <= (wr_qj == 4'd0 && wr_qk == 4'd0) ? READY : WAIT;
        end
        WAIT: begin
          if (hit_j) begin
            qj <= 4'd0;
            vj <= cdb_data;
          end
          if (hit_k) begin
            qk <= 4'd0;
            vk <= cdb_data;
          end
          if ((hit_j || qj == 4'd0) && (hit_k || qk == 4'd0)) state <= READY;
        end
        READY: if (iss) state <= EXEC;
        EXEC:  if (cdb_valid && cdb_label == LABEL) state <= FREE;
        default: state <= FREE;
      endcase
    end
  end
endmodule

module add_rs #(
  parameter int ENTRIES    = 3,
  parameter int LABEL_BASE = 1,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          issueEN,
  input  logic [1:0]    issueOp,
  input  logic [3:0]    issueQj,
  input  logic [DW-1:0] issueVj,
  input  logic [3:0]    issueQk,
  input  logic [DW-1:0] issueVk,
  output logic          full,
  output logic [3:0]    issueLabel,
  input  logic          cdbValid,
  input  logic [3:0]    cdbLabel,
  input  logic [DW-1:0] cdbData,
  input  logic          aluAvailable,
  output logic          aluWEN,
  output logic [1:0]    aluOp,
  output logic [DW-1:0] aluData1,
  output logic [DW-1:0] aluData2,
  output logic [3:0]    aluLabel
);
  logic [ENTRIES-1:0]         free_v, ready_v, disp_oh, sel_oh, wr, iss;
  logic [ENTRIES-1:0][1:0]    op_v;
  logic [ENTRIES-1:0][DW-1:0] vj_v, vk_v;
  logic [3:0]                 eff_qj, eff_qk;
  logic [DW-1:0]              eff_vj, eff_vk;
  logic                       disp_acc;

  // Dispatch-time CDB bypass so a same-cycle broadcast is not missed.
  always_comb begin
    eff_qj = issueQj;
    eff_vj = issueVj;
    eff_qk = issueQk;
    eff_vk = issueVk;
    if (cdbValid && issueQj != 4'd0 && issueQj == cdbLabel) begin
      eff_qj = 4'd0;
      eff_vj = cdbData;
    end
    if (cdbValid && issueQk != 4'd0 && issueQk == cdbLabel) begin
      eff_qk = 4'd0;
      eff_vk = cdbData;
    end
  end

  // Lowest-index FREE entry takes the next dispatch; label 0 when full.
  always_comb begin
    disp_oh    = '0;
    issueLabel = 4'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (free_v[i] && disp_oh == '0) begin
        disp_oh[i] = 1'b1;
        issueLabel = 4'(LABEL_BASE + i);
      end
    end
  end

  assign full     = ~|free_v;
  assign disp_acc = issueEN && !full;
  assign wr       = disp_acc ? disp_oh : '0;
  assign aluWEN   = aluAvailable && (|ready_v);
  assign iss      = aluWEN ? sel_oh : '0;

`ifdef RS_AGE_ORDER_EN
  logic [ENTRIES-1:0][2:0] age;
  logic [2:0]              best_age;

  // Age counts dispatches accepted while the entry is occupied, saturating at 7.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      age <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr[i])
          age[i] <= 3'd0;
        else if (disp_acc && !free_v[i] && age[i] != 3'd7)
          age[i] <= age[i] + 3'd1;
      end
    end
  end

  // Oldest READY entry wins; strict compare keeps the lowest index on ties.
  always_comb begin
    sel_oh   = '0;
    best_age = 3'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready_v[i] && (sel_oh == '0 || age[i] > best_age)) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        best_age  = age[i];
      end
    end
  end
`else
  // Lowest-index READY entry wins.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready_v[i] && sel_oh == '0) sel_oh[i] = 1'b1;
    end
  end
`endif

  // Issue-port mux; outputs stay 0 unless an issue is happening.
  always_comb begin
    aluOp    = '0;
    aluData1 = '0;
    aluData2 = '0;
    aluLabel = 4'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (iss[i]) begin
        aluOp    = op_v[i];
        aluData1 = vj_v[i];
        aluData2 = vk_v[i];
        aluLabel = 4'(LABEL_BASE + i);
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    add_rs_entry #(.DW(DW), .LABEL(4'(LABEL_BASE + g))) u_ent (
      .clk      (clk),
      .nRST     (nRST),
      .wr       (wr[g]),
      .wr_op    (issueOp),
      .wr_qj    (eff_qj),
      .wr_vj    (eff_vj),
      .wr_qk    (eff_qk),
      .wr_vk    (eff_vk),
      .cdb_valid(cdbValid),
      .cdb_label(cdbLabel),
      .cdb_data (cdbData),
      .iss      (iss[g]),
      .is_free  (free_v[g]),
      .is_ready (ready_v[g]),
      .op       (op_v[g]),
      .vj       (vj_v[g]),
      .vk       (vk_v[g])
    );
  end
endmodule
